mul_arbiter: RTL
================

MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one sequential 64x64 multiplier.
REQ-002 Parameter TIMEOUT_CYCLES, default 256, watchdog limit in clocks (used only under MUL_ARB_TIMEOUT_EN).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, named as follows: clk  input  1  rising-edge clock; reset  input  1  synchronous active-high reset.
REQ-004 req  input  N_REQ  per-requester operation request, level.
REQ-005 req_multiplier  input  N_REQ*64  per-requester signed multiplier operand, requester i at bits [64i+63:64i].
REQ-006 req_multiplicand  input  N_REQ*64  per-requester signed multiplicand operand, same packing.
REQ-007 gnt  output  N_REQ  one-hot grant, one-cycle pulse when operands are latched.
REQ-008 done  output  N_REQ  one-hot completion, one-cycle pulse when result is valid.
REQ-009 result  output  128  signed product of the completed operation, held until the next done.
REQ-010 err  output  N_REQ  one-hot timeout pulse, coincident with done.
REQ-011 mul_multiplier, mul_multiplicand  output  64 each  operands driven to the multiplier.
REQ-012 mul_op_start, mul_op_clear  output  1 each  multiplier control.
REQ-013 mul_op_done  input  1  multiplier completion level.
REQ-014 mul_result  input  128  multiplier product.

Function
REQ-015 FSM states: IDLE, START, WAIT_DONE, CLEAR.
REQ-016 IDLE: when req is nonzero, select one requester round-robin, starting at the index after the last granted one; latch its operands and index; pulse gnt[idx]; go to START.
REQ-017 START: assert mul_op_start=1 and mul_op_clear=0 for one cycle; go to WAIT_DONE.
REQ-018 WAIT_DONE: hold mul_op_start=1 and keep the operands stable until mul_op_done=1.
REQ-019 On mul_op_done=1: register mul_result into result; pulse done[idx]; go to CLEAR.
REQ-020 CLEAR: drive mul_op_start=0 and mul_op_clear=1 for exactly one cycle; go to IDLE.
REQ-021 The next grant SHALL occur no earlier than the cycle after CLEAR; back-to-back throughput is multiplier latency plus 3 cycles.
REQ-022 Changes to req or to the operands after grant SHALL be ignored until the operation completes.
REQ-023 A requester holding req after its done SHALL be re-arbitrated behind the other pending requesters.
REQ-024 gnt, done and err SHALL each be one-hot or all-zero in every cycle.
REQ-025 mul_op_start and mul_op_clear SHALL never be high in the same cycle.

Reset
REQ-026 Reset SHALL force: state=IDLE; round-robin pointer=0 (requester 0 has first priority); gnt, done and err=0; result=0; mul_op_start=0; mul_op_clear=0; operand outputs=0.
REQ-027 Reset mid-operation SHALL abort without a done pulse; the next operation starts from IDLE.

Configuration
REQ-028 Macro MUL_ARB_TIMEOUT_EN defined: a counter runs in WAIT_DONE.
REQ-029 If TIMEOUT_CYCLES elapse without mul_op_done, the block SHALL set result=0, pulse done[idx] and err[idx], and go to CLEAR.
REQ-030 Macro MUL_ARB_TIMEOUT_EN undefined: no counter, err tied to 0, and the block waits indefinitely.

Structure
REQ-031 Package mul_arb_pkg SHALL hold the FSM state enum, operand width 64, result width 128, and the default N_REQ.
REQ-032 The round-robin selection SHALL be implemented in sub-module rr_arbiter (inputs req and last_idx; outputs one-hot grant and valid).

Verification
REQ-033 req[0] with operands 3 and 5 -> gnt[0] pulse, op_start high until op_done, done[0] pulse, result=15, then one op_clear cycle.
REQ-034 req[1] with operands -6 and 6 -> result=128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFDC, done[1] only.
REQ-035 req=4'b1111 held from reset -> grant order 0,1,2,3,0; each done precedes the next gnt.
REQ-036 After grant to 1, with req=4'b0110 held -> next grant goes to 2, then 1.
REQ-037 With MUL_ARB_TIMEOUT_EN and a stub multiplier that never asserts op_done -> err[idx] and done[idx] pulse exactly 256 cycles after WAIT_DONE entry, result=0.
REQ-038 reset asserted during WAIT_DONE -> no done pulse, all outputs 0 next cycle, and a new req[3] is granted normally.

Source files
------------

// File: rtl/mul_arb_pkg.sv
// mul_arb_pkg: shared widths, default requester count and FSM state encoding for mul_arbiter.
package mul_arb_pkg;
  localparam int OP_W      = 64;
  localparam int RES_W     = 128;
  localparam int N_REQ_DEF = 4;
  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, CLEAR} state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first requester after last_idx wins.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_idx,
  output logic [N-1:0]  grant,
  output logic          valid
);
  always_comb begin
    grant = '0;
    // scan farthest-to-nearest so the nearest pending requester is written last
    for (int k = N; k >= 1; k--)
      if (req[(int'(last_idx) + k) % N]) grant = N'(1) << ((int'(last_idx) + k) % N);
    valid = |req;
  end
endmodule

// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin sharing of one sequential 64x64 signed multiplier among N_REQ requesters.
// Optional watchdog enabled by defining MUL_ARB_TIMEOUT_EN.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int N_REQ          = N_REQ_DEF,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*OP_W-1:0] req_multiplier,
  input  logic [N_REQ*OP_W-1:0] req_multiplicand,
  output logic [N_REQ-1:0]      gnt,
  output logic [N_REQ-1:0]      done,
  output logic [RES_W-1:0]      result,
  output logic [N_REQ-1:0]      err,
  output logic [OP_W-1:0]       mul_multiplier,
  output logic [OP_W-1:0]       mul_multiplicand,
  output logic                  mul_op_start,
  output logic                  mul_op_clear,
  input  logic                  mul_op_done,
  input  logic [RES_W-1:0]      mul_result
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  state_e             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d, sel_idx;
  logic [N_REQ-1:0]   gnt_q, gnt_d, done_q, done_d, rr_grant;
  logic               rr_valid, tmo;
  logic [RES_W-1:0]   result_q, result_d;
  logic [OP_W-1:0]    mplier_q, mplier_d, mcand_q, mcand_d;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req     (req),
    .last_idx(idx_q),
    .grant   (rr_grant),
    .valid   (rr_valid)
  );

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (rr_grant[i]) sel_idx = IW'(i);
  end

`ifdef MUL_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0] err_q;
  always_comb begin
    cnt_d = (state_q == WAIT_DONE) ? cnt_q + 1'b1 : '0;
    tmo   = (state_q == WAIT_DONE) && !mul_op_done && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  end
  always_ff @(posedge clk) begin
    cnt_q <= reset ? '0 : cnt_d;
    err_q <= (reset || !tmo) ? '0 : N_REQ'(1) << idx_q;
  end
  assign err = err_q;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
  assign tmo = 1'b0;
  assign err = '0;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    gnt_d    = '0;
    done_d   = '0;
    result_d = result_q;
    mplier_d = mplier_q;
    mcand_d  = mcand_q;
    unique case (state_q)
      IDLE: if (rr_valid) begin
        state_d  = START;
        idx_d    = sel_idx;
        gnt_d    = rr_grant;
        mplier_d = req_multiplier[sel_idx*OP_W +: OP_W];
        mcand_d  = req_multiplicand[sel_idx*OP_W +: OP_W];
      end
      START: state_d = WAIT_DONE;
      WAIT_DONE: if (mul_op_done || tmo) begin
        state_d  = CLEAR;
        done_d   = N_REQ'(1) << idx_q;
        result_d = mul_op_done ? mul_result : '0;
      end
      CLEAR: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // idx_q doubles as the round-robin pointer; N_REQ-1 gives requester 0 first priority
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= IW'(N_REQ - 1);
      gnt_q    <= '0;
      done_q   <= '0;
      result_q <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
    end
  end

  assign gnt              = gnt_q;
  assign done             = done_q;
  assign result           = result_q;
  assign mul_multiplier   = mplier_q;
  assign mul_multiplicand = mcand_q;
  assign mul_op_start     = (state_q == START) || (state_q == WAIT_DONE);
  assign mul_op_clear     = (state_q == CLEAR);
endmodule
